// File: rtl/tdc_frame_packer.sv
// Packs buffered TDC event words into frames: header {A5,00,seq,cnt}, payload, optional XOR trailer.
// Latency: first frame word valid one cycle after the trigger (FRAME_LEN words buffered or timeout).
// Backpressure: s_ready = !full regardless of m_ready; output words hold while m_valid && !m_ready.
// Build option: define TDC_PACKER_CHECKSUM_EN to append a trailer word (XOR of header and payload).
module tdc_frame_packer #(
  parameter int DATA_WIDTH = 32,   // only 32 is supported (header layout is 32 bits)
  parameter int FIFO_DEPTH = 16,   // power of 2, >= 4
  parameter int FRAME_LEN  = 8,    // 1..255, <= FIFO_DEPTH
  parameter int TIMEOUT    = 255   // 2..65535
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

`ifdef TDC_PACKER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    TRAILER = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;
`endif

  state_t state_q;
  state_t state_d;

  // Event buffer (first-word-fall-through: head is read combinationally)
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  // Framing state
  logic [15:0]           tcnt;
  logic [7:0]            frame_cnt;
  logic [7:0]            rem;
  logic [7:0]            seq;
  logic                  trigger;
  logic                  hdr_xfer;
  logic                  frame_done;
  logic [LW-1:0]         take;
  logic [DATA_WIDTH-1:0] hdr_word;
`ifdef TDC_PACKER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
`endif

  assign full       = (level == LW'(FIFO_DEPTH));
  assign empty      = (level == '0);
  // Held low during reset so nothing is accepted on the reset edge.
  assign s_ready    = !reset && !full;
  assign push       = s_valid && s_ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = level;
  assign hdr_word   = {8'hA5, 8'h00, seq, frame_cnt};

  // A frame starts once a full frame is buffered, or a partial one has waited long enough.
  assign trigger = (state_q == IDLE) &&
                   ((level >= LW'(FRAME_LEN)) ||
                    ((tcnt == 16'(TIMEOUT - 1)) && !empty));

  // Frame size is fixed at trigger time; later arrivals belong to the next frame.
  assign take = (level >= LW'(FRAME_LEN)) ? LW'(FRAME_LEN) : level;

  // Buffer storage write (no reset needed: contents qualified by level)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Buffer pointers and occupancy; simultaneous push and pop leave level unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Timeout counter: runs only while idling with buffered words
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
    end else if ((state_q != IDLE) || trigger || empty) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 16'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and output word selection
  always_comb begin
    state_d    = state_q;
    m_valid    = 1'b0;
    m_data     = '0;
    m_last     = 1'b0;
    pop        = 1'b0;
    hdr_xfer   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = HEADER;
        end
      end
      HEADER: begin
        m_valid  = 1'b1;
        m_data   = hdr_word;
        hdr_xfer = m_ready;
        if (m_ready) begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // The buffer always holds at least rem words here; empty gating is a safety net.
        m_valid = !empty;
        m_data  = head;
        pop     = m_ready && !empty;
`ifdef TDC_PACKER_CHECKSUM_EN
        if (pop && (rem == 8'd1)) begin
          state_d = TRAILER;
        end
`else
        m_last = (rem == 8'd1);
        if (pop && (rem == 8'd1)) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
`endif
      end
`ifdef TDC_PACKER_CHECKSUM_EN
      TRAILER: begin
        m_valid = 1'b1;
        m_data  = csum;
        m_last  = 1'b1;
        if (m_ready) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame bookkeeping: latched count, remaining payload words, sequence number
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      rem       <= '0;
      seq       <= '0;
    end else begin
      if (trigger) begin
        frame_cnt <= 8'(take);
      end
      if (hdr_xfer) begin
        rem <= frame_cnt;
      end else if (pop) begin
        rem <= rem - 8'd1;
      end
      if (frame_done) begin
        seq <= seq + 8'd1;
      end
    end
  end

`ifdef TDC_PACKER_CHECKSUM_EN
  // Running XOR over header and payload words for the trailer
  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
    end else if (hdr_xfer) begin
      csum <= hdr_word;
    end else if (pop) begin
      csum <= csum ^ head;
    end
  end
`endif

endmodule
